rate_control_gen2: RTL and testbench
====================================

Name: rate_control_gen2

Overview:
Parametrised successor to the first-generation rate controller. It generates a recovered clock with independently programmable high and low half-periods. It applies ±1-cycle drift corrections to the active half-period and tracks the cumulative drift in a saturating signed accumulator. An edge-counted lockout window and an inverse-drift violation check guard the corrections. It sits between edge detection/drift detection and downstream sampling logic.

Parameters:
COUNT_W, 16, width of half-period counters and period inputs
DRIFT_W, 8, width of signed drift accumulator
LOCKOUT_W, 6, width of lockout edge counter

Ports:
sys_dom_i.clk  input  1  system clock
sys_dom_i.sync_rst  input  1  synchronous, active-high reset
enable_i  input  1  run generator; low forces IDLE
clear_state_i  input  1  clears accumulator, sticky flags, lockout; FSM unaffected
high_period_i  input  COUNT_W  high half-period in cycles (0 treated as 1)
low_period_i  input  COUNT_W  low half-period in cycles (0 treated as 1)
drift_detected_i  input  1  drift observation strobe
drift_direction_i  input  1  1 = late (lengthen), 0 = early (shorten)
max_drift_i  input  DRIFT_W-1  accumulator magnitude limit
lockout_edges_i  input  LOCKOUT_W  valid edges to ignore drift after a correction
any_valid_edge_i  input  1  lockout decrement strobe
preempt_threshold_i  input  DRIFT_W-1  used only with optional feature
clk_o  output  1  generated clock level
rise_edge_o  output  1  1-cycle strobe, coincident with clk_o 0->1
fall_edge_o  output  1  1-cycle strobe, coincident with clk_o 1->0
drift_acc_o  output  DRIFT_W  signed accumulator
drift_applied_o  output  1  1-cycle strobe: correction accepted
drift_acc_overflow_o  output  1  sticky: limit would have been exceeded
inverse_drift_violation_o  output  1  1-cycle strobe
lockout_active_o  output  1  lockout counter nonzero
preemptive_o  output  1  1-cycle strobe, optional feature

Behaviour:
- Reset: FSM IDLE. All outputs 0. Counter 0, accumulator 0, lockout 0, last_dir 0, pending_early 0.
- FSM IDLE/HIGH/LOW. All outputs registered.
- IDLE: on enable_i=1, go to HIGH next cycle. Assert clk_o=1 and rise_edge_o that cycle. Load counter = max(high_period_i,1)-1.
- HIGH/LOW: counter decrements each cycle.
  - At 0 in HIGH, go to LOW with fall_edge_o, clk_o=0, and load max(low_period_i,1)-1.
  - At 0 in LOW, go to HIGH with rise_edge_o, clk_o=1, and load from high_period_i.
  - Period inputs are sampled only at load.
- enable_i=0 in any state: next cycle IDLE, clk_o=0. No fall_edge_o is emitted.
- Drift acceptance: drift_detected_i=1, FSM not IDLE, lockout counter 0. On acceptance:
  - drift_applied_o pulses.
  - Late: counter +1 (saturate at all-ones).
  - Early, counter>0: counter -1.
  - Early, counter=0: set pending_early. The next load subtracts 1 (floor 0). pending_early then clears.
  - Lockout loads lockout_edges_i. last_dir = direction.
- Accumulator: late +1, early -1 on acceptance.
  - If the result magnitude would exceed max_drift_i, hold the value at ±max_drift_i and set drift_acc_overflow_o (sticky).
  - The counter correction is still applied when the accumulator saturates.
- Lockout: any_valid_edge_i decrements the counter while it is nonzero.
- Inverse violation: drift_detected_i during lockout with direction != last_dir pulses inverse_drift_violation_o. The drift is otherwise ignored. Same-direction drift during lockout is silently ignored.
- clear_state_i:
  - Zeroes accumulator, overflow, lockout, pending_early. last_dir -> 0.
  - Has priority over a same-cycle drift acceptance; that drift is dropped.
  - Counter and FSM are unaffected.
- Reset mid-operation: returns everything to the reset values next cycle, with no edge strobes.

Optional Feature:
RATE_CONTROL_PREEMPT_EN
- Defined: on each LOW->HIGH load, if |drift_acc_o| >= preempt_threshold_i and preempt_threshold_i != 0, the load is adjusted by one cycle in the accumulator's sign direction.
  - Positive accumulator: +1.
  - Negative accumulator: -1, floor 0.
  - preemptive_o pulses that cycle.
  - The accumulator and lockout are unchanged.
- Undefined: preempt_threshold_i is ignored and preemptive_o is tied 0.

Test Plan:
- Reset, enable, high=3, low=5 -> clk_o period 8, rise_edge_o every 8 cycles, fall_edge_o 3 cycles after each rise.
- high=0, low=0 -> clk_o toggles every cycle (period 2).
- late drift mid-HIGH, lockout_edges_i=2 -> that high phase is 4 cycles, drift_acc_o=1. A same-direction drift before 2 valid edges is ignored. An opposite drift in that window pulses inverse_drift_violation_o.
- max_drift_i=2, three early drifts with lockout 0 -> drift_acc_o=-2, drift_acc_overflow_o=1. The third correction still shortens its phase. clear_state_i -> acc 0, flag 0.
- Early drift on the counter=0 cycle of LOW -> the following HIGH lasts high_period_i-1 cycles.
- With RATE_CONTROL_PREEMPT_EN, acc=+3, threshold=3, high=4 -> every HIGH lasts 5 cycles and preemptive_o pulses at each rise.

Source files
------------

// File: rtl/rate_control_gen2_if.sv
// System clock/reset bundle feeding rate_control_gen2.
interface sys_dom_if;
   logic clk;
   logic sync_rst;

   modport sink (
      input clk,
      input sync_rst
   );
endinterface

// File: rtl/rate_control_gen2.sv
// Recovered-clock generator with programmable half-periods, drift correction and lockout.
// Optional feature: define RATE_CONTROL_PREEMPT_EN for preemptive LOW->HIGH load adjustment.
module rate_control_gen2 #(
   parameter int COUNT_W   = 16,
   parameter int DRIFT_W   = 8,
   parameter int LOCKOUT_W = 6
) (
   sys_dom_if.sink                     sys_dom_i,
   input  logic                        enable_i,
   input  logic                        clear_state_i,
   input  logic [COUNT_W-1:0]          high_period_i,
   input  logic [COUNT_W-1:0]          low_period_i,
   input  logic                        drift_detected_i,
   input  logic                        drift_direction_i,
   input  logic [DRIFT_W-2:0]          max_drift_i,
   input  logic [LOCKOUT_W-1:0]        lockout_edges_i,
   input  logic                        any_valid_edge_i,
   input  logic [DRIFT_W-2:0]          preempt_threshold_i,
   output logic                        clk_o,
   output logic                        rise_edge_o,
   output logic                        fall_edge_o,
   output logic signed [DRIFT_W-1:0]   drift_acc_o,
   output logic                        drift_applied_o,
   output logic                        drift_acc_overflow_o,
   output logic                        inverse_drift_violation_o,
   output logic                        lockout_active_o,
   output logic                        preemptive_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [COUNT_W-1:0]      CNT_MAX = '1;
   localparam logic signed [DRIFT_W:0] ACC_ONE = {{DRIFT_W{1'b0}}, 1'b1};

   state_t                      state_reg;
   logic [COUNT_W-1:0]          cnt_reg;
   logic [LOCKOUT_W-1:0]        lock_reg;
   logic [LOCKOUT_W-1:0]        lock_next;
   logic                        last_dir_reg;
   logic                        pend_reg;

   logic                        accept;
   logic                        violation;
   logic                        early_at_zero;
   logic                        pend_eff;
   logic [COUNT_W-1:0]          cnt_eff;
   logic [COUNT_W-1:0]          rise_load;
   logic                        preempt_hit;

   logic signed [DRIFT_W:0]     acc_wide;
   logic signed [DRIFT_W:0]     acc_lim;
   logic signed [DRIFT_W:0]     acc_neg;
   logic signed [DRIFT_W:0]     acc_step;
   logic signed [DRIFT_W-1:0]   acc_next;
   logic                        ovf_hit;

   // Period 0 behaves as 1; a pending early correction trims one more cycle, floored at 0.
   function automatic logic [COUNT_W-1:0] load_value(input logic [COUNT_W-1:0] period,
                                                     input logic               shorten);
      logic [COUNT_W-1:0] base;
      base = (period == '0) ? '0 : period - 1'b1;
      if (shorten && base != '0) begin
         base = base - 1'b1;
      end
      return base;
   endfunction

   always_comb begin
      accept        = drift_detected_i && (state_reg != IDLE) && (lock_reg == '0) && !clear_state_i;
      violation     = drift_detected_i && (lock_reg != '0) && (drift_direction_i != last_dir_reg);
      early_at_zero = accept && !drift_direction_i && (cnt_reg == '0);
      pend_eff      = !clear_state_i && (pend_reg || early_at_zero);

      // Correction is folded in before the terminal-count check of this cycle.
      cnt_eff = cnt_reg;
      if (accept) begin
         if (drift_direction_i) begin
            if (cnt_reg != CNT_MAX) begin
               cnt_eff = cnt_reg + 1'b1;
            end
         end else if (cnt_reg != '0) begin
            cnt_eff = cnt_reg - 1'b1;
         end
      end
   end

   always_comb begin
      acc_wide = {drift_acc_o[DRIFT_W-1], drift_acc_o};
      acc_lim  = {2'b00, max_drift_i};
      acc_neg  = -acc_lim;
      acc_step = drift_direction_i ? acc_wide + ACC_ONE : acc_wide - ACC_ONE;
      acc_next = acc_step[DRIFT_W-1:0];
      ovf_hit  = 1'b0;
      if (acc_step > acc_lim) begin
         acc_next = acc_lim[DRIFT_W-1:0];
         ovf_hit  = 1'b1;
      end else if (acc_step < acc_neg) begin
         acc_next = acc_neg[DRIFT_W-1:0];
         ovf_hit  = 1'b1;
      end
   end

   always_comb begin
      lock_next = lock_reg;
      if (clear_state_i) begin
         lock_next = '0;
      end else if (accept) begin
         lock_next = lockout_edges_i;
      end else if (any_valid_edge_i && lock_reg != '0) begin
         lock_next = lock_reg - 1'b1;
      end
   end

`ifdef RATE_CONTROL_PREEMPT_EN
   logic [DRIFT_W-1:0] acc_mag;
`else
   logic unused_preempt;
   assign unused_preempt = ^preempt_threshold_i;
`endif

   always_comb begin
      rise_load   = load_value(high_period_i, pend_eff);
      preempt_hit = 1'b0;
`ifdef RATE_CONTROL_PREEMPT_EN
      acc_mag = drift_acc_o[DRIFT_W-1] ? (~drift_acc_o + 1'b1) : drift_acc_o;
      if (preempt_threshold_i != '0 && acc_mag >= {1'b0, preempt_threshold_i}) begin
         preempt_hit = 1'b1;
         if (!drift_acc_o[DRIFT_W-1]) begin
            if (rise_load != CNT_MAX) begin
               rise_load = rise_load + 1'b1;
            end
         end else if (rise_load != '0) begin
            rise_load = rise_load - 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge sys_dom_i.clk) begin
      if (sys_dom_i.sync_rst) begin
         state_reg                 <= IDLE;
         cnt_reg                   <= '0;
         lock_reg                  <= '0;
         last_dir_reg              <= 1'b0;
         pend_reg                  <= 1'b0;
         clk_o                     <= 1'b0;
         rise_edge_o               <= 1'b0;
         fall_edge_o               <= 1'b0;
         drift_acc_o               <= '0;
         drift_applied_o           <= 1'b0;
         drift_acc_overflow_o      <= 1'b0;
         inverse_drift_violation_o <= 1'b0;
         lockout_active_o          <= 1'b0;
         preemptive_o              <= 1'b0;
      end else begin
         rise_edge_o               <= 1'b0;
         fall_edge_o               <= 1'b0;
         preemptive_o              <= 1'b0;
         drift_applied_o           <= accept;
         inverse_drift_violation_o <= violation;
         pend_reg                  <= pend_eff;
         lock_reg                  <= lock_next;
         lockout_active_o          <= (lock_next != '0);

         if (!enable_i) begin
            state_reg <= IDLE;
            clk_o     <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg   <= HIGH;
                  clk_o       <= 1'b1;
                  rise_edge_o <= 1'b1;
                  cnt_reg     <= load_value(high_period_i, pend_eff);
                  pend_reg    <= 1'b0;
               end
               HIGH: begin
                  if (cnt_eff == '0) begin
                     state_reg   <= LOW;
                     clk_o       <= 1'b0;
                     fall_edge_o <= 1'b1;
                     cnt_reg     <= load_value(low_period_i, pend_eff);
                     pend_reg    <= 1'b0;
                  end else begin
                     cnt_reg <= cnt_eff - 1'b1;
                  end
               end
               LOW: begin
                  if (cnt_eff == '0) begin
                     state_reg    <= HIGH;
                     clk_o        <= 1'b1;
                     rise_edge_o  <= 1'b1;
                     cnt_reg      <= rise_load;
                     pend_reg     <= 1'b0;
                     preemptive_o <= preempt_hit;
                  end else begin
                     cnt_reg <= cnt_eff - 1'b1;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  clk_o     <= 1'b0;
               end
            endcase
         end

         if (clear_state_i) begin
            drift_acc_o          <= '0;
            drift_acc_overflow_o <= 1'b0;
            last_dir_reg         <= 1'b0;
         end else if (accept) begin
            drift_acc_o  <= acc_next;
            last_dir_reg <= drift_direction_i;
            if (ovf_hit) begin
               drift_acc_overflow_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rate_control_gen2.sv
// Scoreboard bench for rate_control_gen2: phase-length reference model, queue of expectations, decoupled monitor.
module tb_rate_control_gen2;
   localparam int COUNT_W   = 16;
   localparam int DRIFT_W   = 8;
   localparam int LOCKOUT_W = 6;
   localparam int RMAX      = 1 << COUNT_W;

   logic clk = 1'b0;
   logic srst;
   always #5 clk = ~clk;

   sys_dom_if sys_dom();
   assign sys_dom.clk      = clk;
   assign sys_dom.sync_rst = srst;

   logic                      enable_i, clear_state_i, drift_detected_i, drift_direction_i, any_valid_edge_i;
   logic [COUNT_W-1:0]        high_period_i, low_period_i;
   logic [DRIFT_W-2:0]        max_drift_i, preempt_threshold_i;
   logic [LOCKOUT_W-1:0]      lockout_edges_i;
   logic                      clk_o, rise_edge_o, fall_edge_o, drift_applied_o, drift_acc_overflow_o;
   logic                      inverse_drift_violation_o, lockout_active_o, preemptive_o;
   logic signed [DRIFT_W-1:0] drift_acc_o;

   rate_control_gen2 #(.COUNT_W(COUNT_W), .DRIFT_W(DRIFT_W), .LOCKOUT_W(LOCKOUT_W)) dut (
      .sys_dom_i                 (sys_dom),
      .enable_i                  (enable_i),
      .clear_state_i             (clear_state_i),
      .high_period_i             (high_period_i),
      .low_period_i              (low_period_i),
      .drift_detected_i          (drift_detected_i),
      .drift_direction_i         (drift_direction_i),
      .max_drift_i               (max_drift_i),
      .lockout_edges_i           (lockout_edges_i),
      .any_valid_edge_i          (any_valid_edge_i),
      .preempt_threshold_i       (preempt_threshold_i),
      .clk_o                     (clk_o),
      .rise_edge_o               (rise_edge_o),
      .fall_edge_o               (fall_edge_o),
      .drift_acc_o               (drift_acc_o),
      .drift_applied_o           (drift_applied_o),
      .drift_acc_overflow_o      (drift_acc_overflow_o),
      .inverse_drift_violation_o (inverse_drift_violation_o),
      .lockout_active_o          (lockout_active_o),
      .preemptive_o              (preemptive_o)
   );

   typedef struct {
      int cyc;
      bit clk, rise, fall, applied, ovf, viol, lock_act, pre;
      int acc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_count = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   // Reference model state: phase 0 idle / 1 high / 2 low, cycles remaining in phase.
   int m_phase = 0, m_rem = 1, m_acc = 0, m_lock = 0;
   bit m_ovf = 0, m_last = 0, m_pend = 0, m_clk = 0;

   always @(posedge clk) cyc_count <= cyc_count + 1;

   function automatic int load_len(input int p, input bit shorten);
      int len;
      len = (p == 0) ? 1 : p;
      if (shorten && len > 1) len--;
      return len;
   endfunction

   task automatic model_step(input int cyc);
      exp_t e;
      bit   accept, viol, early0, pend_now;
      int   rem_eff, nacc, lim;
      e = '{cyc: cyc, default: 0};
      if (srst) begin
         m_phase = 0; m_rem = 1; m_acc = 0; m_lock = 0;
         m_ovf = 0; m_last = 0; m_pend = 0; m_clk = 0;
      end else begin
         accept   = drift_detected_i && m_phase != 0 && m_lock == 0 && !clear_state_i;
         viol     = drift_detected_i && m_lock != 0 && drift_direction_i != m_last;
         early0   = accept && !drift_direction_i && m_rem == 1;
         pend_now = !clear_state_i && (m_pend || early0);
         rem_eff  = m_rem;
         if (accept && drift_direction_i) rem_eff = (m_rem < RMAX) ? m_rem + 1 : RMAX;
         else if (accept && m_rem > 1) rem_eff = m_rem - 1;
         m_pend = pend_now;
         if (!enable_i) begin
            m_phase = 0; m_clk = 0;
         end else if (m_phase == 0) begin
            m_phase = 1; m_clk = 1; e.rise = 1;
            m_rem = load_len(int'(high_period_i), pend_now); m_pend = 0;
         end else if (rem_eff > 1) begin
            m_rem = rem_eff - 1;
         end else if (m_phase == 1) begin
            m_phase = 2; m_clk = 0; e.fall = 1;
            m_rem = load_len(int'(low_period_i), pend_now); m_pend = 0;
         end else begin
            m_phase = 1; m_clk = 1; e.rise = 1;
            m_rem = load_len(int'(high_period_i), pend_now); m_pend = 0;
`ifdef RATE_CONTROL_PREEMPT_EN
            if (preempt_threshold_i != 0 && ((m_acc < 0) ? -m_acc : m_acc) >= int'(preempt_threshold_i)) begin
               e.pre = 1;
               if (m_acc > 0) m_rem = (m_rem < RMAX) ? m_rem + 1 : RMAX;
               else if (m_rem > 1) m_rem--;
            end
`endif
         end
         if (clear_state_i) begin
            m_acc = 0; m_ovf = 0; m_lock = 0; m_pend = 0; m_last = 0;
         end else if (accept) begin
            lim  = int'(max_drift_i);
            nacc = m_acc + (drift_direction_i ? 1 : -1);
            if (nacc > lim) begin m_acc = lim; m_ovf = 1; end
            else if (nacc < -lim) begin m_acc = -lim; m_ovf = 1; end
            else m_acc = nacc;
            m_lock = int'(lockout_edges_i);
            m_last = drift_direction_i;
         end else if (any_valid_edge_i && m_lock > 0) begin
            m_lock--;
         end
         e.applied = accept;
         e.viol    = viol;
      end
      e.clk = m_clk; e.acc = m_acc; e.ovf = m_ovf; e.lock_act = (m_lock != 0);
      exp_q.push_back(e);
   endtask

   // Apply current inputs for one clock: model predicts, then the DUT samples them.
   task automatic step();
      model_step(cyc_count + 1);
      @(posedge clk);
      #1;
      drift_detected_i = 0;
      any_valid_edge_i = 0;
      clear_state_i    = 0;
   endtask

   task automatic drift(input bit dir);
      drift_detected_i  = 1;
      drift_direction_i = dir;
      step();
   endtask

   // Monitor: pops one expectation per cycle and compares the registered outputs.
   initial begin
      exp_t e;
      bit   ok;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc_count) begin
            e  = exp_q.pop_front();
            ok = (clk_o === e.clk) && (rise_edge_o === e.rise) && (fall_edge_o === e.fall) &&
                 (drift_applied_o === e.applied) && (drift_acc_overflow_o === e.ovf) &&
                 (inverse_drift_violation_o === e.viol) && (lockout_active_o === e.lock_act) &&
                 (preemptive_o === e.pre) && (int'(drift_acc_o) == e.acc) && !$isunknown(drift_acc_o);
            tests_run++;
            if (!ok) begin
               tests_failed++;
               $display("[TB] FAIL cyc%0d outputs: got clk=%b rise=%b fall=%b app=%b ovf=%b viol=%b lock=%b pre=%b acc=%0d, want clk=%b rise=%b fall=%b app=%b ovf=%b viol=%b lock=%b pre=%b acc=%0d",
                        e.cyc, clk_o, rise_edge_o, fall_edge_o, drift_applied_o, drift_acc_overflow_o,
                        inverse_drift_violation_o, lockout_active_o, preemptive_o, drift_acc_o,
                        e.clk, e.rise, e.fall, e.applied, e.ovf, e.viol, e.lock_act, e.pre, e.acc);
            end else begin
               $display("[TB] cyc%0d ok clk=%b rise=%b fall=%b app=%b viol=%b acc=%0d ovf=%b lock=%b",
                        e.cyc, clk_o, rise_edge_o, fall_edge_o, drift_applied_o,
                        inverse_drift_violation_o, drift_acc_o, drift_acc_overflow_o, lockout_active_o);
            end
         end
      end
   end

   initial begin
      srst = 1; enable_i = 0; clear_state_i = 0; drift_detected_i = 0; drift_direction_i = 0;
      any_valid_edge_i = 0; high_period_i = 3; low_period_i = 5; max_drift_i = 7;
      lockout_edges_i = 0; preempt_threshold_i = 0;
      @(posedge clk); #1;
      repeat (3) step();
      srst = 0;
      step();

      // Basic 3/5 waveform.
      enable_i = 1;
      repeat (30) step();

      // Zero periods toggle every cycle.
      high_period_i = 0; low_period_i = 0;
      repeat (10) step();

      // Late drift mid-HIGH with lockout of 2 edges, then same and opposite drifts inside the window.
      high_period_i = 3; low_period_i = 5; lockout_edges_i = 2;
      for (int i = 0; i < 40 && !(m_phase == 1 && m_rem == 2); i++) step();
      drift(1);
      drift(1);
      drift(0);
      any_valid_edge_i = 1; step();
      step();
      any_valid_edge_i = 1; step();
      repeat (12) step();

      // Saturation: three early drifts with max 2, then clear.
      clear_state_i = 1; step();
      max_drift_i = 2; lockout_edges_i = 0;
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 40 && !(m_phase != 0 && m_rem > 1); i++) step();
         drift(0);
         repeat (3) step();
      end
      clear_state_i = 1; step();
      repeat (5) step();

      // Early drift on the terminal cycle of LOW shortens the next HIGH.
      max_drift_i = 7;
      for (int i = 0; i < 40 && !(m_phase == 2 && m_rem == 1); i++) step();
      drift(0);
      repeat (12) step();

      // Disable, re-enable, then reset mid-operation.
      enable_i = 0; repeat (3) step();
      enable_i = 1; repeat (6) step();
      srst = 1; step(); srst = 0;
      repeat (6) step();

      // Randomized traffic.
      for (int c = 0; c < 1200; c++) begin
         if (c % 100 == 0) begin
            high_period_i       = COUNT_W'($urandom_range(0, 6));
            low_period_i        = COUNT_W'($urandom_range(0, 6));
            max_drift_i         = (DRIFT_W-1)'($urandom_range(0, 4));
            lockout_edges_i     = LOCKOUT_W'($urandom_range(0, 3));
            preempt_threshold_i = (DRIFT_W-1)'($urandom_range(0, 3));
         end
         srst              = ($urandom_range(0, 199) == 0);
         enable_i          = ($urandom_range(0, 39) != 0);
         clear_state_i     = ($urandom_range(0, 49) == 0);
         drift_detected_i  = ($urandom_range(0, 5) == 0);
         drift_direction_i = 1'($urandom_range(0, 1));
         any_valid_edge_i  = ($urandom_range(0, 2) == 0);
         step();
      end
      srst = 0;
      repeat (3) step();

      repeat (2) @(posedge clk);
      #2;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
